// File: rtl/axi4_if.sv
// rtl/axi4_if.sv - AXI4-Lite channel bundle with manager/subordinate views
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport manager (
    output awaddr, awvalid, input awready,
    output wdata, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport subordinate (
    input awaddr, awvalid, output awready,
    input wdata, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi4_lite_arb.sv
// rtl/axi4_lite_arb.sv - multi-requester AXI4-Lite manager; AXI4_LITE_ARB_RR_EN selects round-robin over fixed priority
module axi4_lite_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  axi4_if.manager                       m_axi
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;

`ifdef AXI4_LITE_ARB_RR_EN
  logic [IDX_W-1:0] ptr;
  assign start = ptr;

  // Pointer moves just past the winner on every grant so each requester gets a turn
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr <= '0;
    end else if (state == IDLE && sel_any) begin
      ptr <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end
  end
`else
  assign start = '0;
`endif

  // Scan from 'start' in wrap order; the first valid requester found wins
  always_comb begin
    logic [IDX_W-1:0] cand;
    int               j;
    sel_idx = '0;
    sel_any = 1'b0;
    cand    = '0;
    j       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = j[IDX_W-1:0];
      if (req_valid[cand]) begin
        sel_idx = cand;
        sel_any = 1'b1;
      end
    end
  end

  // Accept strobe follows the live request in IDLE so the grant lands in the cycle it is seen
  always_comb begin
    req_ready = '0;
    if (aresetn && state == IDLE && sel_any) req_ready[sel_idx] = 1'b1;
  end

  // Transaction sequencer: captures the winner's command and walks it through the AXI channels
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      gnt           <= '0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      m_axi.awaddr  <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (sel_any) begin
            gnt <= sel_idx;
            if (req_write[sel_idx]) begin
              m_axi.awaddr  <= req_addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
              m_axi.wdata   <= req_wdata[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
              m_axi.awvalid <= 1'b1;
              m_axi.wvalid  <= 1'b1;
              state         <= WR_ADDR;
            end else begin
              m_axi.araddr  <= req_addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
              m_axi.arvalid <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          // Each channel retires on its own handshake; a low valid means it already did
          if (m_axi.awready) m_axi.awvalid <= 1'b0;
          if (m_axi.wready)  m_axi.wvalid  <= 1'b0;
          if ((!m_axi.awvalid || m_axi.awready) && (!m_axi.wvalid || m_axi.wready)) begin
            m_axi.bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi.bvalid) begin
            m_axi.bready   <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= m_axi.bresp;
            rsp_valid[gnt] <= 1'b1;
            state          <= RESP;
          end
        end
        RD_ADDR: begin
          if (m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi.rvalid) begin
            m_axi.rready   <= 1'b0;
            rsp_rdata      <= m_axi.rdata;
            rsp_resp       <= m_axi.rresp;
            rsp_valid[gnt] <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_arb.sv
// tb/tb_axi4_lite_arb.sv - scoreboard bench for axi4_lite_arb with a stallable subordinate model
module tb_axi4_lite_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;

  axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi ();

  axi4_lite_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi(m_axi)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_idx;
  int   grant_cyc[$];
  int   last_grant_cyc = 0;
  int   rsp_cnt = 0;
  int   rsp_cyc = 0;

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Response scoreboard
  always @(negedge aclk) begin
    if (aresetn && rsp_valid != '0) begin
      mon_idx = -1;
      for (int i = 0; i < N; i++) if (rsp_valid[i]) mon_idx = i;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: rsp_valid=%b rdata=%h resp=%0d, required no response", rsp_valid, rsp_rdata, rsp_resp);
      end else begin
        mon_e = exp_q.pop_front();
        if (!$onehot(rsp_valid) || mon_idx != mon_e.idx || rsp_rdata !== mon_e.rdata || rsp_resp !== mon_e.resp) begin
          failures++;
          $display("FAIL rsp_data: got req=%0d (rsp_valid=%b) rdata=%h resp=%0d, required req=%0d rdata=%h resp=%0d",
                   mon_idx, rsp_valid, rsp_rdata, rsp_resp, mon_e.idx, mon_e.rdata, mon_e.resp);
        end
      end
      rsp_cnt++;
      rsp_cyc = cyc;
    end
  end

  // Grant monitor
  always @(negedge aclk) begin
    #1;
    if (aresetn && req_ready != '0) begin
      checks++;
      if (!$onehot(req_ready) || (req_ready & ~req_valid) != '0) begin
        failures++;
        $display("FAIL grant_onehot: req_ready=%b req_valid=%b, required one-hot subset of valid", req_ready, req_valid);
      end
      grant_cyc.push_back(cyc);
      last_grant_cyc = cyc;
    end
  end

  // Subordinate model: acts at the falling edge on handshakes made at the previous rising edge
  logic [31:0] mem [16];
  int          aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  bresp_force = 2'b00, rresp_force = 2'b00;
  int          aw_cnt, w_cnt, b_cnt, r_cnt;
  bit          hs_aw, hs_w, hs_b, hs_ar, hs_r, pv_aw, pv_w, pv_ar;
  bit          got_aw, got_w, b_pend, r_pend;
  logic [31:0] pv_awaddr, pv_wdata, pv_araddr, cap_awaddr, cap_wdata, cap_araddr;

  always @(negedge aclk) begin
    if (!aresetn) begin
      m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.arready = 1'b0;
      m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00;
      m_axi.rvalid = 1'b0; m_axi.rresp = 2'b00; m_axi.rdata = '0;
      {hs_aw, hs_w, hs_b, hs_ar, hs_r, pv_aw, pv_w, pv_ar} = '0;
      {got_aw, got_w, b_pend, r_pend} = '0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (pv_aw) begin
        checks++;
        if (hs_aw ? (m_axi.awvalid !== 1'b0) : (m_axi.awvalid !== 1'b1 || m_axi.awaddr !== pv_awaddr)) begin
          failures++;
          $display("FAIL aw_rule: hs=%0d awvalid=%b awaddr=%h, required valid=%0d addr=%h", hs_aw, m_axi.awvalid, m_axi.awaddr, !hs_aw, pv_awaddr);
        end
      end
      if (pv_w) begin
        checks++;
        if (hs_w ? (m_axi.wvalid !== 1'b0) : (m_axi.wvalid !== 1'b1 || m_axi.wdata !== pv_wdata)) begin
          failures++;
          $display("FAIL w_rule: hs=%0d wvalid=%b wdata=%h, required valid=%0d data=%h", hs_w, m_axi.wvalid, m_axi.wdata, !hs_w, pv_wdata);
        end
      end
      if (pv_ar) begin
        checks++;
        if (hs_ar ? (m_axi.arvalid !== 1'b0) : (m_axi.arvalid !== 1'b1 || m_axi.araddr !== pv_araddr)) begin
          failures++;
          $display("FAIL ar_rule: hs=%0d arvalid=%b araddr=%h, required valid=%0d addr=%h", hs_ar, m_axi.arvalid, m_axi.araddr, !hs_ar, pv_araddr);
        end
      end
      if (hs_aw) begin got_aw = 1'b1; cap_awaddr = pv_awaddr; aw_cnt = 0; end
      if (hs_w)  begin got_w = 1'b1; cap_wdata = pv_wdata; w_cnt = 0; end
      if (got_aw && got_w) begin
        mem[cap_awaddr[5:2]] = cap_wdata;
        got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b1; b_cnt = 0;
      end
      if (hs_b) m_axi.bvalid = 1'b0;
      if (hs_ar) begin r_pend = 1'b1; r_cnt = 0; cap_araddr = pv_araddr; end
      if (hs_r) m_axi.rvalid = 1'b0;

      m_axi.awready = m_axi.awvalid && (aw_cnt >= aw_delay);
      if (m_axi.awvalid && !m_axi.awready) aw_cnt++;
      m_axi.wready = m_axi.wvalid && (w_cnt >= w_delay);
      if (m_axi.wvalid && !m_axi.wready) w_cnt++;
      m_axi.arready = m_axi.arvalid;
      if (b_pend) begin
        if (b_cnt >= b_delay) begin
          m_axi.bvalid = 1'b1; m_axi.bresp = bresp_force; b_pend = 1'b0;
        end else b_cnt++;
      end
      if (r_pend) begin
        if (r_cnt >= r_delay) begin
          m_axi.rvalid = 1'b1; m_axi.rdata = mem[cap_araddr[5:2]]; m_axi.rresp = rresp_force; r_pend = 1'b0;
        end else r_cnt++;
      end

      pv_aw = m_axi.awvalid; pv_awaddr = m_axi.awaddr; hs_aw = m_axi.awvalid && m_axi.awready;
      pv_w  = m_axi.wvalid;  pv_wdata  = m_axi.wdata;  hs_w  = m_axi.wvalid && m_axi.wready;
      pv_ar = m_axi.arvalid; pv_araddr = m_axi.araddr; hs_ar = m_axi.arvalid && m_axi.arready;
      hs_b  = m_axi.bvalid && m_axi.bready;
      hs_r  = m_axi.rvalid && m_axi.rready;
    end
  end

  task automatic issue(input int i, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input bit want, input logic [31:0] erd, input logic [1:0] eresp);
    int t = 0;
    @(negedge aclk);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = addr;
    req_wdata[i*DW +: DW] = data;
    #1;
    while (!req_ready[i] && t < 100) begin @(negedge aclk); #1; t++; end
    checks++;
    if (!req_ready[i]) begin
      failures++;
      $display("FAIL grant_timeout: req %0d req_ready=%b, required 1", i, req_ready[i]);
    end else if (want) begin
      exp_q.push_back('{i, erd, eresp});
    end
    @(negedge aclk);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int t = 0;
    while (rsp_cnt < target && t < 200) begin @(negedge aclk); #2; t++; end
    checks++;
    if (rsp_cnt < target) begin
      failures++;
      $display("FAIL rsp_timeout: got %0d responses, required %0d", rsp_cnt, target);
    end
  endtask

  logic [142:0] outs;
  task automatic check_outs_zero(input string name);
    outs = {req_ready, rsp_valid, rsp_rdata, rsp_resp, m_axi.awvalid, m_axi.wvalid, m_axi.arvalid,
            m_axi.bready, m_axi.rready, m_axi.awaddr, m_axi.wdata, m_axi.araddr};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL %s: outputs=%h, required all zero", name, outs);
    end
  endtask

  int order [5];
  int base, n0, t;

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    repeat (3) @(negedge aclk);
    #2;
    check_outs_zero("reset_state");
    @(negedge aclk);
    #2 aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // All requesters read continuously
`ifdef AXI4_LITE_ARB_RR_EN
    order = '{0, 1, 2, 3, 0};
`else
    order = '{0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 5; k++) exp_q.push_back('{order[k], 32'h1000_0004 + order[k], 2'b00});
    base = grant_cyc.size();
    n0 = rsp_cnt;
    @(negedge aclk);
    for (int i = 0; i < N; i++) begin
      req_write[i] = 1'b0;
      req_addr[i*AW +: AW] = 32'h10 + 4 * i;
    end
    req_valid = '1;
    t = 0;
    while (grant_cyc.size() < base + 5 && t < 100) begin @(negedge aclk); #2; t++; end
    @(negedge aclk);
    req_valid = '0;
    wait_rsp(n0 + 5);
    for (int k = 0; k < 4; k++)
      check_int("grant_spacing", (grant_cyc.size() > base + k + 1) ? grant_cyc[base+k+1] - grant_cyc[base+k] : -1, 4);
    repeat (3) @(negedge aclk);

    // Write then read from requester 0, zero-wait latency
    n0 = rsp_cnt;
    issue(0, 1'b1, 32'h04, 32'hDEAD_BEEF, 1'b1, 32'h0, 2'b00);
    wait_rsp(n0 + 1);
    check_int("wr_latency", rsp_cyc - last_grant_cyc, 3);
    issue(0, 1'b0, 32'h04, 32'h0, 1'b1, 32'hDEAD_BEEF, 2'b00);
    wait_rsp(n0 + 2);
    check_int("rd_latency", rsp_cyc - last_grant_cyc, 3);

    // Stalled channels
    aw_delay = 3;
    issue(3, 1'b1, 32'h08, 32'h1234_5678, 1'b1, 32'h0, 2'b00);
    wait_rsp(n0 + 3);
    check_int("wr_aw_stall_latency", rsp_cyc - last_grant_cyc, 6);
    aw_delay = 0; w_delay = 2;
    issue(3, 1'b1, 32'h18, 32'h0BAD_F00D, 1'b1, 32'h0, 2'b00);
    wait_rsp(n0 + 4);
    check_int("wr_w_stall_latency", rsp_cyc - last_grant_cyc, 5);
    w_delay = 0; r_delay = 5;
    issue(3, 1'b0, 32'h08, 32'h0, 1'b1, 32'h1234_5678, 2'b00);
    wait_rsp(n0 + 5);
    check_int("rd_r_stall_latency", rsp_cyc - last_grant_cyc, 8);
    r_delay = 0;

    // Error response passthrough
    rresp_force = 2'b10;
    issue(2, 1'b0, 32'h04, 32'h0, 1'b1, 32'hDEAD_BEEF, 2'b10);
    wait_rsp(n0 + 6);
    rresp_force = 2'b00;
    bresp_force = 2'b11;
    issue(1, 1'b1, 32'h20, 32'h55AA_55AA, 1'b1, 32'h0, 2'b11);
    wait_rsp(n0 + 7);
    bresp_force = 2'b00;

    // Reset while waiting for the write response
    b_delay = 8;
    issue(1, 1'b1, 32'h0C, 32'hCAFE_F00D, 1'b0, 32'h0, 2'b00);
    t = 0;
    while (!m_axi.bready && t < 50) begin @(negedge aclk); #2; t++; end
    check_int("bready_seen", int'(m_axi.bready), 1);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 check_outs_zero("reset_mid");
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b1;
    b_delay = 0;
    repeat (12) @(negedge aclk);
    n0 = rsp_cnt;
    issue(2, 1'b0, 32'h0C, 32'h0, 1'b1, 32'hCAFE_F00D, 2'b00);
    wait_rsp(n0 + 1);
    check_int("post_reset_latency", rsp_cyc - last_grant_cyc, 3);

    repeat (5) @(negedge aclk);
    check_int("pending_expected", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
